mem_stage_ctrl: RTL and testbench

//  MEM-stage consumer of the EXE->MEM pipeline register outputs (wb_en, mem_r_en, mem_w_en, alu_result, st_val, dest).

---
 rtl/arm_pkg.sv | 13 +
 rtl/mem_stage_ctrl_if.sv | 21 ++
 rtl/mem_timeout_counter.sv | 26 ++
 rtl/mem_stage_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared constants and MEM-stage state encoding
package arm_pkg;

    localparam int MEM_BASE   = 1024;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data-memory req/ack bus between MEM stage and memory
interface mem_stage_ctrl_if #(
    parameter int BIT_NUMBER = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [BIT_NUMBER-1:0] mem_addr;
    logic [BIT_NUMBER-1:0] mem_wdata;
    logic [BIT_NUMBER-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - ack-wait counter, terminal count at TIMEOUT-1
module mem_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage load/store sequencer with upstream freeze; MEM_ALIGN_CHECK_EN adds misalign trap
module mem_stage_ctrl
    import arm_pkg::*;
#(
    parameter int BIT_NUMBER = 32,
    parameter int MEM_BASE   = arm_pkg::MEM_BASE,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [BIT_NUMBER-1:0] alu_result_in,
    input  logic [BIT_NUMBER-1:0] st_val_in,
    input  logic [3:0]            dest_in,
    output logic                  freeze,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic [BIT_NUMBER-1:0] alu_result,
    output logic [BIT_NUMBER-1:0] mem_data,
    output logic [3:0]            dest,
    output logic                  mem_err,
    mem_stage_ctrl_if.master      mem_bus
);
    mem_state_t            state, state_nxt;
    logic                  acc;
    logic                  tc;
    logic                  freeze_c;
    logic                  wb_kill;
    logic [BIT_NUMBER-1:0] word_addr;

    assign acc       = mem_r_en_in | mem_w_en_in;
    assign word_addr = (alu_result_in - BIT_NUMBER'(MEM_BASE)) >> WORD_SHIFT;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign;
    logic bad_load_q;

    assign misalign = acc & (|alu_result_in[1:0]);
    assign wb_kill  = (state == DONE) & bad_load_q;
`else
    assign wb_kill  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        freeze_c  = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    freeze_c  = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                    state_nxt = misalign ? DONE : ACCESS;
`else
                    state_nxt = ACCESS;
`endif
                end
            end
            ACCESS: begin
                freeze_c = 1'b1;
                if (mem_bus.mem_ack || tc) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset overrides the combinational freeze so upstream is released at once
    assign freeze     = freeze_c & ~rst;
    assign wb_en      = wb_en_in & ~freeze & ~wb_kill;
    assign mem_r_en   = mem_r_en_in & ~freeze;
    assign alu_result = alu_result_in;
    assign dest       = dest_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_bus.mem_req   <= 1'b0;
            mem_bus.mem_we    <= 1'b0;
            mem_bus.mem_addr  <= '0;
            mem_bus.mem_wdata <= '0;
            mem_data          <= '0;
            mem_err           <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            bad_load_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_ALIGN_CHECK_EN
                    if (misalign) begin
                        mem_err    <= 1'b1;
                        mem_data   <= '0;
                        bad_load_q <= mem_r_en_in;
                    end else
`endif
                    if (acc) begin
                        mem_bus.mem_req   <= 1'b1;
                        mem_bus.mem_we    <= mem_w_en_in & ~mem_r_en_in;
                        mem_bus.mem_addr  <= word_addr;
                        mem_bus.mem_wdata <= st_val_in;
                    end
                end
                ACCESS: begin
                    if (mem_bus.mem_ack) begin
                        if (!mem_bus.mem_we) begin
                            mem_data <= mem_bus.mem_rdata;
                        end
                        mem_bus.mem_req <= 1'b0;
                    end else if (tc) begin
                        mem_bus.mem_req <= 1'b0;
                        mem_data        <= '0;
                        mem_err         <= 1'b1;
                    end
                end
                default: begin
`ifdef MEM_ALIGN_CHECK_EN
                    bad_load_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ACCESS),
        .enable ((state == ACCESS) && !mem_bus.mem_ack),
        .tc     (tc)
    );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en_in = 1'b0;
    logic        mem_r_en_in = 1'b0;
    logic        mem_w_en_in = 1'b0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] st_val_in = '0;
    logic [3:0]  dest_in = '0;
    logic        freeze, wb_en, mem_r_en, mem_err;
    logic [31:0] alu_result, mem_data;
    logic [3:0]  dest;

    mem_stage_ctrl_if #(.BIT_NUMBER(32)) bus ();

    mem_stage_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .wb_en_in      (wb_en_in),
        .mem_r_en_in   (mem_r_en_in),
        .mem_w_en_in   (mem_w_en_in),
        .alu_result_in (alu_result_in),
        .st_val_in     (st_val_in),
        .dest_in       (dest_in),
        .freeze        (freeze),
        .wb_en         (wb_en),
        .mem_r_en      (mem_r_en),
        .alu_result    (alu_result),
        .mem_data      (mem_data),
        .dest          (dest),
        .mem_err       (mem_err),
        .mem_bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
        logic        wb;
        int          fcnt;
        int          reqc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ack_k: ACCESS cycle (1-based) in which mem_ack is pulsed; 0 means never
    task automatic run_mem(input logic r, input logic w, input logic [31:0] addr,
                           input logic [31:0] stv, input int ack_k, input logic [31:0] rdata);
        exp_t e;
        exp_t f;
        logic mis;
        int   fc;
        int   reqc;
        logic done;
        logic bad_req;
        logic wb_leak;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`endif
        e.addr  = (addr - 32'd1024) >> 2;
        e.we    = w & ~r;
        e.wdata = stv;
        e.wb    = r & ~mis;
        if (mis) begin
            e.data = 32'h0; e.err = 1'b1; e.fcnt = 1; e.reqc = 0;
        end else if (ack_k == 0) begin
            e.data = 32'h0; e.err = 1'b1; e.fcnt = 16; e.reqc = 15;
        end else begin
            e.data = r ? rdata : m_data; e.err = m_err; e.fcnt = ack_k + 1; e.reqc = ack_k;
        end
        m_data = e.data;
        m_err  = e.err;
        sb.push_back(e);

        @(negedge clk);
        wb_en_in = r; mem_r_en_in = r; mem_w_en_in = w;
        alu_result_in = addr; st_val_in = stv; dest_in = 4'd7;
        #1;
        chk("idle_freeze", freeze, 1'b1);
        fc = 1; reqc = 0; done = 1'b0; bad_req = 1'b0; wb_leak = 1'b0;
        f = sb[0];
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 32'hBAD0_0000 + 32'(cyc);
            #1;
            if (!freeze) begin
                done = 1'b1;
                break;
            end
            fc++;
            if (wb_en || mem_r_en) wb_leak = 1'b1;
            if (bus.mem_req) begin
                reqc++;
                if (bus.mem_addr !== f.addr || bus.mem_we !== f.we || bus.mem_wdata !== f.wdata)
                    bad_req = 1'b1;
            end
            if (cyc == ack_k) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rdata;
            end
        end
        chk("done_reached", done, 1'b1);
        e = sb.pop_front();
        chk("req_fields_held", bad_req, 1'b0);
        chk("bubble_during_freeze", wb_leak, 1'b0);
        chk("freeze_cycles", 64'(fc), 64'(e.fcnt));
        chk("req_cycles", 64'(reqc), 64'(e.reqc));
        chk("done_mem_req", bus.mem_req, 1'b0);
        chk("done_mem_data", mem_data, e.data);
        chk("done_mem_err", mem_err, e.err);
        chk("done_wb_en", wb_en, e.wb);
        chk("done_dest", dest, 4'd7);
        @(negedge clk);
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        #1;
        chk("back_idle_freeze", freeze, 1'b0);
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        wb_en_in = 1'b1;
        #2;
        chk("rst_freeze", freeze, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_wb_pass", wb_en, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // plain ALU op: zero-latency pass-through, no bus activity
        @(negedge clk);
        wb_en_in = 1'b1; dest_in = 4'd3; alu_result_in = 32'd99;
        #1;
        chk("alu_freeze", freeze, 1'b0);
        chk("alu_wb_en", wb_en, 1'b1);
        chk("alu_dest", dest, 4'd3);
        chk("alu_result", alu_result, 32'd99);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("alu_no_req", bus.mem_req, 1'b0);
        end
        wb_en_in = 1'b0;

        run_mem(1'b1, 1'b0, 32'd1028, 32'h0, 3, 32'hDEADBEEF);
        run_mem(1'b0, 1'b1, 32'd1024, 32'h12345678, 2, 32'h0);

        // stray ack while idle must not load data
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        chk("stray_ack_ignored", mem_data, m_data);

        run_mem(1'b1, 1'b1, 32'd1036, 32'h5555_AAAA, 1, 32'hCAFE0001);
        run_mem(1'b1, 1'b0, 32'd0, 32'h0, 2, 32'h0BADF00D);
        run_mem(1'b1, 1'b0, 32'd1040, 32'h0, 0, 32'h0);

        // reset in the middle of a load
        @(negedge clk);
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; alu_result_in = 32'd1044;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_req", bus.mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", bus.mem_req, 1'b0);
        chk("midrst_freeze", freeze, 1'b0);
        chk("midrst_mem_err", mem_err, 1'b0);
        chk("midrst_mem_data", mem_data, 32'h0);
        m_data = '0;
        m_err  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0;

        run_mem(1'b1, 1'b0, 32'd1032, 32'h0, 1, 32'hA5A5_5A5A);
        run_mem(1'b1, 1'b0, 32'd1026, 32'h0, 1, 32'h1357_9BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
